// File: rtl/u_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : u_mem_pkg
// Purpose : Shared types for the instruction/data memory arbiter: FSM state
//           encoding, owner encoding and the word-address width.
// Ports   : none (package)
// Macros  : none
// Revision: 1.0 - initial release
// ============================================================================
package u_mem_pkg;

  localparam int ADDR_W = 30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    IF_DROP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // The owner of the memory port follows directly from the FSM state; a
  // dropped fetch still owns the port until the memory answers.
  function automatic owner_e owner_of(state_e s);
    owner_e o;
    case (s)
      IF_BUSY, IF_DROP: o = OWN_IF;
      D_BUSY:           o = OWN_D;
      default:          o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/u_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : u_mem_arb_if
// Purpose : Bundle of the fetch requester, data requester and memory port
//           signals served by u_mem_arb.
// Ports   : slave modport  - arbiter view (requester inputs, memory outputs)
//           master modport - environment view (drives requests and memory)
// Macros  : none
// Revision: 1.0 - initial release
// ============================================================================
interface u_mem_arb_if #(
  parameter int DATA_W = 32
);

  logic                        if_req_i;
  logic [u_mem_pkg::ADDR_W-1:0] if_addr_i;
  logic                        if_flush_i;
  logic [DATA_W-1:0]           if_rdata_o;
  logic                        if_busywait_o;

  logic                        d_req_i;
  logic                        d_we_i;
  logic [DATA_W/8-1:0]         d_be_i;
  logic [u_mem_pkg::ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0]           d_wdata_i;
  logic [DATA_W-1:0]           d_rdata_o;
  logic                        d_busywait_o;

  logic                        mem_req_o;
  logic                        mem_we_o;
  logic [DATA_W/8-1:0]         mem_be_o;
  logic [u_mem_pkg::ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0]           mem_wdata_o;
  logic [DATA_W-1:0]           mem_rdata_i;
  logic                        mem_ready_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_rdata_o, if_busywait_o,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output d_rdata_o, d_busywait_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_rdata_o, if_busywait_o,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  d_rdata_o, d_busywait_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i
  );

endinterface
`default_nettype wire

// File: rtl/u_mem_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module  : u_arb_starve_cnt
// Purpose : Counts data grants made while a fetch is waiting and flags when
//           the count reaches LIMIT so the fetch can be let through.
// Ports   : clk_i, rst_ni (async active-low)
//           inc      - a data grant was made while a fetch waited
//           clr      - fetch granted, or no fetch pending in IDLE
//           at_limit - count equals LIMIT
// Macros  : instantiated only when ARB_FAIR_EN is defined
// Revision: 1.0 - initial release
// ============================================================================
module u_arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  input  wire logic inc,
  input  wire logic clr,
  output logic      at_limit
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] c_limit = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_limit = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/u_mem_arb.sv
`default_nettype none
// ============================================================================
// Module  : u_mem_arb
// Purpose : Arbitrates a single-ported, variable-latency memory between the
//           instruction fetch and the data (MEM stage) requesters. Requests
//           are latched at grant and held on the memory port until
//           mem_ready_i; flushed fetches complete on the memory side and
//           their data is discarded.
// Ports   : clk_i  - clock
//           rst_ni - asynchronous active-low reset
//           bus    - u_mem_arb_if.slave (requesters and memory port)
// Macros  : ARB_FAIR_EN - after STARVE_LIMIT consecutive data grants with a
//           fetch waiting, the fetch wins the next arbitration.
// Revision: 1.0 - initial release
// ============================================================================
module u_mem_arb
  import u_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input wire logic   clk_i,
  input wire logic   rst_ni,
  u_mem_arb_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  state_e              r_state;
  logic                r_mem_req;
  logic                r_we;
  logic [BE_W-1:0]     r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  owner_e w_owner;
  logic   w_fetch_wins;
  logic   w_grant_d;
  logic   w_grant_if;
  logic   w_if_done;
  logic   w_d_done;

  assign w_owner = owner_of(r_state);

`ifdef ARB_FAIR_EN
  logic w_at_limit;
  logic w_cnt_inc;
  logic w_cnt_clr;

  assign w_cnt_inc = w_grant_d && bus.if_req_i;
  assign w_cnt_clr = (r_state == IDLE) && (w_grant_if || !bus.if_req_i);

  u_arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc     (w_cnt_inc),
    .clr     (w_cnt_clr),
    .at_limit(w_at_limit)
  );

  assign w_fetch_wins = bus.if_req_i && w_at_limit;
`else
  // Strict data priority: the starvation limit has no effect in this build.
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign w_fetch_wins = 1'b0;
`endif

  assign w_grant_d  = (r_state == IDLE) && bus.d_req_i && !w_fetch_wins;
  assign w_grant_if = (r_state == IDLE) && bus.if_req_i && !w_grant_d;

  // A flush arriving together with mem_ready_i still discards the data, so
  // the fetch completion is suppressed by the flush as well as by IF_DROP.
  assign w_if_done = (w_owner == OWN_IF) && (r_state != IF_DROP) &&
                     bus.mem_ready_i && !bus.if_flush_i;
  assign w_d_done  = (w_owner == OWN_D) && bus.mem_ready_i;

  assign bus.if_busywait_o = bus.if_req_i && !w_if_done;
  assign bus.d_busywait_o  = bus.d_req_i && !w_d_done;
  assign bus.if_rdata_o    = bus.mem_rdata_i;
  assign bus.d_rdata_o     = bus.mem_rdata_i;

  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_we;
  assign bus.mem_be_o    = r_be;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state   <= D_BUSY;
            r_mem_req <= 1'b1;
            r_we      <= bus.d_we_i;
            r_be      <= bus.d_be_i;
            r_addr    <= bus.d_addr_i;
            r_wdata   <= bus.d_wdata_i;
          end else if (w_grant_if) begin
            r_state   <= IF_BUSY;
            r_mem_req <= 1'b1;
            r_we      <= 1'b0;
            r_be      <= '1;
            r_addr    <= bus.if_addr_i;
            r_wdata   <= '0;
          end
        end
        IF_BUSY: begin
          if (bus.mem_ready_i) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end else if (bus.if_flush_i) begin
            r_state   <= IF_DROP;
          end
        end
        D_BUSY, IF_DROP: begin
          if (bus.mem_ready_i) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_u_mem_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_u_mem_arb
// Purpose : Directed self-checking bench for u_mem_arb.
// Ports   : none
// Macros  : ARB_FAIR_EN - selects the fairness expectation in the final test
// Revision: 1.0 - initial release
// ============================================================================
module tb_u_mem_arb;
  import u_mem_pkg::*;

  logic clk;
  logic rst_ni;
  int   total;
  int   bad;

  u_mem_arb_if #(.DATA_W(32)) bus ();

  u_mem_arb #(
    .STARVE_LIMIT(4),
    .DATA_W      (32)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int dg;
    bit fetch_seen;

    total = 0;
    bad   = 0;
    rst_ni = 1'b0;
    bus.if_req_i = 1'b0;  bus.if_addr_i = '0;  bus.if_flush_i = 1'b0;
    bus.d_req_i  = 1'b0;  bus.d_we_i = 1'b0;   bus.d_be_i = '0;
    bus.d_addr_i = '0;    bus.d_wdata_i = '0;
    bus.mem_rdata_i = '0; bus.mem_ready_i = 1'b0;

    // Reset state
    step(); step();
    check("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
    check("rst_mem_be", 64'(bus.mem_be_o), 64'd0);
    check("rst_if_bw", 64'(bus.if_busywait_o), 64'd0);
    check("rst_d_bw", 64'(bus.d_busywait_o), 64'd0);
    rst_ni = 1'b1;
    step();

    // 1: fetch only
    bus.if_req_i = 1'b1; bus.if_addr_i = 30'h10; bus.mem_rdata_i = 32'h13;
    #1 check("t1_req_bw", 64'(bus.if_busywait_o), 64'd1);
    step();
    check("t1_mem_req", 64'(bus.mem_req_o), 64'd1);
    check("t1_mem_addr", 64'(bus.mem_addr_o), 64'h10);
    check("t1_mem_we", 64'(bus.mem_we_o), 64'd0);
    check("t1_mem_be", 64'(bus.mem_be_o), 64'hF);
    check("t1_wait_bw", 64'(bus.if_busywait_o), 64'd1);
    step();
    bus.mem_ready_i = 1'b1;
    #1 check("t1_done_bw", 64'(bus.if_busywait_o), 64'd0);
    check("t1_rdata", 64'(bus.if_rdata_o), 64'h13);
    step();
    bus.mem_ready_i = 1'b0; bus.if_req_i = 1'b0;
    check("t1_idle_req", 64'(bus.mem_req_o), 64'd0);

    // 2: simultaneous fetch and store; data first
    bus.if_req_i = 1'b1; bus.if_addr_i = 30'h20;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_be_i = 4'b0011;
    bus.d_addr_i = 30'h40; bus.d_wdata_i = 32'hDEADBEEF;
    step();
    check("t2_d_addr", 64'(bus.mem_addr_o), 64'h40);
    check("t2_d_we", 64'(bus.mem_we_o), 64'd1);
    check("t2_d_be", 64'(bus.mem_be_o), 64'h3);
    check("t2_d_wdata", 64'(bus.mem_wdata_o), 64'hDEADBEEF);
    bus.mem_ready_i = 1'b1;
    #1 check("t2_d_bw", 64'(bus.d_busywait_o), 64'd0);
    check("t2_if_bw", 64'(bus.if_busywait_o), 64'd1);
    step();
    bus.mem_ready_i = 1'b0; bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
    check("t2_gap_req", 64'(bus.mem_req_o), 64'd0);
    step();
    check("t2_if_req", 64'(bus.mem_req_o), 64'd1);
    check("t2_if_addr", 64'(bus.mem_addr_o), 64'h20);
    check("t2_if_we", 64'(bus.mem_we_o), 64'd0);
    bus.mem_ready_i = 1'b1;
    #1 check("t2_if_done", 64'(bus.if_busywait_o), 64'd0);
    step();
    bus.mem_ready_i = 1'b0; bus.if_req_i = 1'b0;

    // 4: data address changes while D_BUSY; ready in IDLE ignored
    bus.d_req_i = 1'b1; bus.d_addr_i = 30'h40; bus.mem_ready_i = 1'b1;
    #1 check("t4_idle_ready", 64'(bus.d_busywait_o), 64'd1);
    bus.mem_ready_i = 1'b0;
    step();
    bus.d_addr_i = 30'h80;
    #1 check("t4_addr_a", 64'(bus.mem_addr_o), 64'h40);
    step();
    check("t4_addr_b", 64'(bus.mem_addr_o), 64'h40);
    check("t4_bw", 64'(bus.d_busywait_o), 64'd1);
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hCAFEF00D;
    #1 check("t4_rdata", 64'(bus.d_rdata_o), 64'hCAFEF00D);
    check("t4_done_bw", 64'(bus.d_busywait_o), 64'd0);
    check("t4_addr_c", 64'(bus.mem_addr_o), 64'h40);
    step();
    bus.mem_ready_i = 1'b0; bus.d_req_i = 1'b0;

    // 3: flush while IF_BUSY, ready 3 cycles later
    bus.if_req_i = 1'b1; bus.if_addr_i = 30'h30;
    step();
    bus.if_flush_i = 1'b1;
    #1 check("t3_flush_bw", 64'(bus.if_busywait_o), 64'd1);
    step();
    bus.if_flush_i = 1'b0; bus.if_addr_i = 30'h50;
    check("t3_drop_req", 64'(bus.mem_req_o), 64'd1);
    check("t3_drop_addr", 64'(bus.mem_addr_o), 64'h30);
    check("t3_drop_bw", 64'(bus.if_busywait_o), 64'd1);
    step();
    check("t3_drop_addr2", 64'(bus.mem_addr_o), 64'h30);
    step();
    bus.mem_ready_i = 1'b1;
    #1 check("t3_ready_bw", 64'(bus.if_busywait_o), 64'd1);
    step();
    bus.mem_ready_i = 1'b0;
    check("t3_idle_req", 64'(bus.mem_req_o), 64'd0);
    check("t3_idle_bw", 64'(bus.if_busywait_o), 64'd1);
    step();
    check("t3_new_addr", 64'(bus.mem_addr_o), 64'h50);
    check("t3_new_req", 64'(bus.mem_req_o), 64'd1);
    bus.mem_ready_i = 1'b1;
    #1 check("t3_new_bw", 64'(bus.if_busywait_o), 64'd0);
    step();
    bus.mem_ready_i = 1'b0;

    // 3b: flush coincident with ready: completes, data discarded
    step();
    check("t3b_req", 64'(bus.mem_req_o), 64'd1);
    bus.if_flush_i = 1'b1; bus.mem_ready_i = 1'b1;
    #1 check("t3b_bw", 64'(bus.if_busywait_o), 64'd1);
    step();
    bus.if_flush_i = 1'b0; bus.mem_ready_i = 1'b0; bus.if_req_i = 1'b0;
    check("t3b_idle_req", 64'(bus.mem_req_o), 64'd0);
    step();
    check("t3b_stay_idle", 64'(bus.mem_req_o), 64'd0);

    // 5: async reset during D_BUSY
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 30'h44; bus.d_be_i = 4'hF;
    step();
    check("t5_busy", 64'(bus.mem_req_o), 64'd1);
    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1 check("t5_rst_req", 64'(bus.mem_req_o), 64'd0);
    check("t5_rst_addr", 64'(bus.mem_addr_o), 64'd0);
    check("t5_rst_state", 64'(dut.r_state), 64'(IDLE));
    step();
    rst_ni = 1'b1;
    step();

    // 6: both requesters held continuously
    bus.if_req_i = 1'b1; bus.if_addr_i = 30'h60;
    bus.d_req_i = 1'b1; bus.d_addr_i = 30'h70;
    dg = 0;
    fetch_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.mem_req_o) begin
        if (bus.mem_addr_o == 30'h60) fetch_seen = 1'b1;
        else dg++;
        bus.mem_ready_i = 1'b1;
      end else begin
        bus.mem_ready_i = 1'b0;
      end
      if (fetch_seen || dg >= 6) break;
    end
    bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
`ifdef ARB_FAIR_EN
    check("t6_fetch_seen", 64'(fetch_seen), 64'd1);
    check("t6_data_grants", 64'(dg), 64'd4);
`else
    check("t6_fetch_starved", 64'(fetch_seen), 64'd0);
    check("t6_data_grants", 64'(dg), 64'd6);
`endif
    step();
    bus.mem_ready_i = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/u_mem_arb.md
Name: u_mem_arb

Overview:
- Arbitrates one single-ported, variable-latency memory between the instruction-fetch requester (u_if) and the data requester (MEM stage).
- Generates the busywait that stalls each requester.
- Latches the request at grant and holds it stable on the memory port until mem_ready_i.
- Handles fetch flushes while a fetch is in flight: the memory access completes and its data is discarded.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits (used only with ARB_FAIR_EN).
- DATA_W, 32: data bus width; byte enables are DATA_W/8 bits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request, level, held until busywait low
- if_addr_i  in  30  fetch word address [31:2]
- if_flush_i  in  1  abandon current fetch (branch/flush)
- if_rdata_o  out  DATA_W  fetch read data, valid when if_req_i && !if_busywait_o
- if_busywait_o  out  1  fetch stall
- d_req_i  in  1  data request, level
- d_we_i  in  1  write enable
- d_be_i  in  DATA_W/8  byte enables
- d_addr_i  in  30  data word address [31:2]
- d_wdata_i  in  DATA_W  write data
- d_rdata_o  out  DATA_W  load data
- d_busywait_o  out  1  data stall
- mem_req_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_addr_o  out  30  memory word address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ready_i
- mem_ready_i  in  1  one-cycle completion pulse

Behaviour:
- States: IDLE, IF_BUSY, D_BUSY, IF_DROP.
- Reset (async, rst_ni=0):
  - state=IDLE; mem_req_o/mem_we_o=0; mem_be_o/mem_addr_o/mem_wdata_o=0.
  - Latched regs=0; starve count=0.
  - Busywaits are combinational, so both read 0 with no request.
- IDLE:
  - d_req_i has priority over if_req_i.
  - On grant, latch addr/we/be/wdata (fetch: we=0, be=all 1s).
  - Go to D_BUSY or IF_BUSY at the next edge.
  - mem_req_o is registered and asserts the cycle after grant.
- Memory port: mem_* outputs are driven only from latched registers and stay stable while mem_req_o=1 even if requester inputs change.
- IF_BUSY/D_BUSY:
  - Hold mem_req_o until mem_ready_i.
  - In the mem_ready_i cycle, the owner's busywait=0 and rdata passes combinationally from mem_rdata_i.
  - Next state is IDLE and mem_req_o=0.
  - Minimum latency is 2 cycles from request to busywait low (1 arbitration + 1 memory).
- Busywait: *_busywait_o = *_req_i && !(owner && mem_ready_i && state!=IF_DROP).
- Fetch flush, state IF_BUSY:
  - if_flush_i=1 without mem_ready_i: go to IF_DROP.
  - if_flush_i=1 with mem_ready_i in the same cycle: complete normally, but if_busywait_o stays 1 so the data is discarded.
- IF_DROP:
  - mem_req_o stays high until mem_ready_i; data is discarded; if_busywait_o=if_req_i.
  - Then IDLE; the new fetch address is arbitrated afresh.
- Flush in IDLE or D_BUSY: no effect.
- Back-to-back: a requester may keep its req high after completion; it is re-arbitrated in the following IDLE cycle. Each transaction costs at least 1 IDLE cycle.
- mem_ready_i in IDLE: ignored.
- Reset mid-transaction: the memory access is abandoned; the memory side is reset by the same rst_ni.
- Idle rdata: if_rdata_o and d_rdata_o equal mem_rdata_i unconditionally; they are qualified only by busywait.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - A starve counter increments on each data grant made while if_req_i=1.
  - When the counter equals STARVE_LIMIT and both requests are present in IDLE, the fetch wins.
  - The counter clears on any fetch grant or when if_req_i=0 in IDLE.
- Undefined: strict data priority; the counter logic is absent.

Decomposition:
- Package u_mem_pkg:
  - State enum (IDLE/IF_BUSY/D_BUSY/IF_DROP).
  - Owner encoding.
  - Word-address width constant (30).
- Sub-module u_arb_starve_cnt (counter + limit compare), instantiated only under ARB_FAIR_EN. Everything else stays in u_mem_arb.

Test Plan:
1. Only fetch, addr 0x10, mem_ready_i one cycle after mem_req_o rises:
   - mem_addr_o=0x10, mem_we_o=0.
   - if_busywait_o falls in the ready cycle; if_rdata_o=mem_rdata_i=0x00000013.
2. Fetch and data (store, addr 0x40, be=4'b0011, wdata 0xDEADBEEF) requested in the same cycle:
   - Data granted first with mem_we_o=1 and mem_be_o=4'b0011.
   - Fetch granted after the data completes plus 1 IDLE cycle.
3. if_flush_i pulsed while IF_BUSY with memory ready delayed 3 cycles:
   - mem_req_o stays high with the old address until ready; if_busywait_o stays 1.
   - The next fetch is to the new address.
4. Change d_addr_i from 0x40 to 0x80 while D_BUSY: mem_addr_o stays 0x40 throughout.
5. rst_ni low during D_BUSY: mem_req_o=0 and state IDLE immediately, without waiting for a clock edge.
6. ARB_FAIR_EN, STARVE_LIMIT=4, d_req_i and if_req_i held high continuously: fetch is granted after exactly 4 data grants.
